// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the unified-memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT)
//   owner_t     : which requester owns the current transaction
//   BE_W        : byte-enable width for the default 32-bit data path
//   be_width()  : byte-enable width for an arbitrary data width
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int DEF_DATA_W = 32;
  localparam int BE_W       = DEF_DATA_W / 8;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: counts cycles spent waiting for a memory response.
// Ports:
//   clk, reset (async active-low)
//   clr    : restart the count (asserted on entry to WAIT)
//   en     : count this cycle (high while in WAIT)
//   expire : high during the TIMEOUT-th enabled cycle since the last clear
// TIMEOUT = 0 disables the timer: expire is tied low.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = clk ^ reset ^ clr ^ en;
      assign expire        = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [CW-1:0] count;

      // Wait-cycle counter; never wraps in practice because WAIT is left on expire.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          count <= '0;
        end else if (clr) begin
          count <= '0;
        end else if (en) begin
          count <= count + 1'b1;
        end else begin
          count <= count;
        end
      end

      // Count holds k-1 during the k-th WAIT cycle, so this fires on cycle TIMEOUT.
      assign expire = en && (count == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// port (if_*) and the load/store port (d_*). One transaction in flight,
// response timeout turns a missing mem_rvalid into an error response.
// Ports:
//   clk, reset (async active-low)
//   if_req/if_addr -> if_gnt/if_rvalid/if_rdata/if_err
//   d_req/d_we/d_addr/d_wdata/d_be -> d_gnt/d_rvalid/d_rdata/d_err
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be <- mem_gnt/mem_rvalid/mem_rdata
//   busy : high whenever the FSM is not IDLE
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority with D over IF.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  arb_state_t state;
  owner_t     owner;
  owner_t     winner;
  logic       tmr_clr;
  logic       tmr_en;
  logic       expire;

`ifdef MEM_ARB_RR_EN
  owner_t last_owner;
`endif

  // Arbitration: who would win if a grant were issued this cycle.
  always_comb begin
    winner = OWN_IF;
`ifdef MEM_ARB_RR_EN
    // On contention, favour whoever did not win the previous grant.
    if (if_req && d_req) begin
      winner = (last_owner == OWN_D) ? OWN_IF : OWN_D;
    end else if (d_req) begin
      winner = OWN_D;
    end else begin
      winner = OWN_IF;
    end
`else
    if (d_req) begin
      winner = OWN_D;
    end else begin
      winner = OWN_IF;
    end
`endif
  end

  assign tmr_clr = (state == ISSUE) && mem_gnt;
  assign tmr_en  = (state == WAIT);

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (expire)
  );

  // Arbiter FSM with all handshake outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_D;
`ifdef MEM_ARB_RR_EN
      last_owner <= OWN_D;
`endif
      busy       <= 1'b0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      d_gnt      <= 1'b0;
      d_rvalid   <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else begin
      // gnt/rvalid/err are single-cycle pulses unless re-asserted below.
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_err    <= 1'b0;
      d_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state   <= ISSUE;
            busy    <= 1'b1;
            mem_req <= 1'b1;
            owner   <= winner;
`ifdef MEM_ARB_RR_EN
            last_owner <= winner;
`endif
            if (winner == OWN_D) begin
              d_gnt     <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_be    <= d_be;
            end else begin
              // Fetches are full-word reads.
              if_gnt    <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_be    <= '1;
            end
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            state   <= WAIT;
            mem_req <= 1'b0;
          end else begin
            state <= ISSUE;
          end
        end
        WAIT: begin
          // A real response beats a timeout landing in the same cycle.
          if (mem_rvalid) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (owner == OWN_D) begin
              d_rvalid <= 1'b1;
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end else begin
                d_rdata <= d_rdata;
              end
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else if (expire) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (owner == OWN_D) begin
              d_rvalid <= 1'b1;
              d_err    <= 1'b1;
            end else begin
              if_rvalid <= 1'b1;
              if_err    <= 1'b1;
            end
          end else begin
            state <= WAIT;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter.
// The bench owns a reference memory (requester view) and a separate physical
// memory (written only through the mem_* bus) and predicts every response.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid, if_err;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic          d_gnt, d_rvalid, d_err;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_gnt, mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [16];
  logic [31:0] phys    [16];
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;
  bit          last_d;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // Expected winner when both ports request together.
  function automatic bit pick_d_on_contention();
`ifdef MEM_ARB_RR_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
  endtask

  // Request was driven this cycle; expect the grant next cycle, then let the
  // memory stall for gdly cycles before accepting.
  task automatic grant_phase(input bit is_d, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input int gdly, input bit stray);
    step();
    chk1("gnt_owner", is_d ? d_gnt : if_gnt, 1'b1);
    chk1("gnt_other", is_d ? if_gnt : d_gnt, 1'b0);
    chk1("rvalid_clear", if_rvalid | d_rvalid, 1'b0);
    chk1("mem_req_on", mem_req, 1'b1);
    chk1("busy_issue", busy, 1'b1);
    chk32("mem_addr", mem_addr, addr);
    chk1("mem_we", mem_we, is_d & we);
    if (is_d && we) begin
      chk32("mem_wdata", mem_wdata, wdata);
      chk32("mem_be", {28'd0, mem_be}, {28'd0, be});
    end
    last_d = is_d;
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
    for (int i = 0; i < gdly; i++) begin
      mem_rvalid = stray;
      step();
      chk1("stall_req", mem_req, 1'b1);
      chk32("stall_addr", mem_addr, addr);
      chk1("stall_busy", busy, 1'b1);
      chk1("no_dup_gnt", if_gnt | d_gnt, 1'b0);
      chk1("stall_no_rvalid", if_rvalid | d_rvalid, 1'b0);
    end
    mem_rvalid = 1'b0;
    mem_gnt = 1'b1;
    if (mem_we) phys[mem_addr[5:2]] = merge(phys[mem_addr[5:2]], mem_wdata, mem_be);
    step();
    mem_gnt = 1'b0;
    chk1("mem_req_off", mem_req, 1'b0);
    chk1("busy_wait", busy, 1'b1);
  endtask

  // In WAIT: respond after rdly cycles and check the delivered response.
  task automatic resp_phase(input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be, input int rdly);
    for (int i = 0; i < rdly; i++) begin
      chk1("early_rvalid", if_rvalid | d_rvalid, 1'b0);
      step();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = mem_we ? $urandom : phys[mem_addr[5:2]];
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (is_d) begin
      if (we) ref_mem[addr[5:2]] = merge(ref_mem[addr[5:2]], wdata, be);
      else exp_d_rdata = ref_mem[addr[5:2]];
    end else begin
      exp_if_rdata = ref_mem[addr[5:2]];
    end
    chk1("rvalid_owner", is_d ? d_rvalid : if_rvalid, 1'b1);
    chk1("rvalid_other", is_d ? if_rvalid : d_rvalid, 1'b0);
    chk1("err_clear", if_err | d_err, 1'b0);
    chk32("if_rdata", if_rdata, exp_if_rdata);
    chk32("d_rdata", d_rdata, exp_d_rdata);
    chk1("busy_done", busy, 1'b0);
  endtask

  initial begin
    bit          w, we;
    logic [31:0] a, wd;
    logic [3:0]  be;
    int          n, n_sim;

    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    exp_if_rdata = '0; exp_d_rdata = '0; last_d = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      phys[i]    = ref_mem[i];
    end
    ref_mem[1] = 32'h00A0_0113;
    phys[1]    = 32'h00A0_0113;

    // Reset state
    step(); step();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_gnt", if_gnt | d_gnt, 1'b0);
    chk1("rst_rvalid", if_rvalid | d_rvalid, 1'b0);
    chk1("rst_err", if_err | d_err, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'd0);
    chk32("rst_if_rdata", if_rdata, 32'd0);
    chk32("rst_d_rdata", d_rdata, 32'd0);
    reset = 1'b1;
    step();

    // IF-only fetch
    drive(1'b0, 1'b0, 32'h0000_0004, 32'd0, 4'd0);
    grant_phase(1'b0, 1'b0, 32'h0000_0004, 32'd0, 4'd0, 0, 1'b0);
    resp_phase(1'b0, 1'b0, 32'h0000_0004, 32'd0, 4'd0, 1);
    chk32("fetch_value", if_rdata, 32'h00A0_0113);

    // D store then read-back of the merged word
    drive(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011);
    grant_phase(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 1, 1'b0);
    resp_phase(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 2);
    drive(1'b1, 1'b0, 32'h0000_0100, 32'd0, 4'd0);
    grant_phase(1'b1, 1'b0, 32'h0000_0100, 32'd0, 4'd0, 0, 1'b0);
    resp_phase(1'b1, 1'b0, 32'h0000_0100, 32'd0, 4'd0, 0);
    chk32("store_low_half", {16'd0, d_rdata[15:0]}, 32'h0000_BEEF);

    // Simultaneous requests
`ifdef MEM_ARB_RR_EN
    n_sim = 4;
`else
    n_sim = 2;
`endif
    if_req = 1'b1; if_addr = 32'h0000_0020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0024; d_wdata = '0; d_be = '0;
    for (int k = 0; k < n_sim; k++) begin
      w = (if_req && d_req) ? pick_d_on_contention() : d_req;
      a = w ? 32'h0000_0024 : 32'h0000_0020;
      grant_phase(w, 1'b0, a, 32'd0, 4'd0, 0, 1'b0);
      resp_phase(w, 1'b0, a, 32'd0, 4'd0, 0);
`ifdef MEM_ARB_RR_EN
      if (k < n_sim - 2) begin
        if (w) d_req = 1'b1; else if_req = 1'b1;
      end
`endif
    end

    // Memory backpressure with stray mem_rvalid during ISSUE
    drive(1'b1, 1'b0, 32'h0000_000C, 32'd0, 4'd0);
    grant_phase(1'b1, 1'b0, 32'h0000_000C, 32'd0, 4'd0, 5, 1'b1);
    resp_phase(1'b1, 1'b0, 32'h0000_000C, 32'd0, 4'd0, 1);

    // Timeout on a load
    drive(1'b1, 1'b0, 32'h0000_0008, 32'd0, 4'd0);
    grant_phase(1'b1, 1'b0, 32'h0000_0008, 32'd0, 4'd0, 0, 1'b0);
    n = 0;
    while (d_rvalid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk32("timeout_cycles", 32'(n), 32'(TO));
    chk1("timeout_err", d_err, 1'b1);
    chk1("timeout_if_quiet", if_rvalid, 1'b0);
    chk32("timeout_rdata_kept", d_rdata, exp_d_rdata);
    chk1("timeout_idle", busy, 1'b0);
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    chk1("late_rvalid_ignored", if_rvalid | d_rvalid, 1'b0);
    chk1("stray_gnt_ignored", busy | mem_req, 1'b0);
    chk32("late_rdata_ignored", d_rdata, exp_d_rdata);
    drive(1'b1, 1'b0, 32'h0000_0010, 32'd0, 4'd0);
    grant_phase(1'b1, 1'b0, 32'h0000_0010, 32'd0, 4'd0, 0, 1'b0);
    resp_phase(1'b1, 1'b0, 32'h0000_0010, 32'd0, 4'd0, 0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      w  = 1'($urandom_range(0, 1));
      we = w & 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 15)) << 2;
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      drive(w, we, a, wd, be);
      grant_phase(w, we, a, wd, be, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      resp_phase(w, we, a, wd, be, $urandom_range(0, 4));
    end

    // Reset in the middle of a WAIT
    drive(1'b0, 1'b0, 32'h0000_0004, 32'd0, 4'd0);
    grant_phase(1'b0, 1'b0, 32'h0000_0004, 32'd0, 4'd0, 0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_req", mem_req, 1'b0);
    chk32("async_rst_addr", mem_addr, 32'd0);
    chk32("async_rst_if_rdata", if_rdata, 32'd0);
    chk32("async_rst_d_rdata", d_rdata, 32'd0);
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    reset = 1'b1;
    step();
    chk1("post_rst_no_rvalid", if_rvalid | d_rvalid, 1'b0);
    chk1("post_rst_idle", busy, 1'b0);
    last_d = 1'b1;
    drive(1'b0, 1'b0, 32'h0000_0004, 32'd0, 4'd0);
    grant_phase(1'b0, 1'b0, 32'h0000_0004, 32'd0, 4'd0, 0, 1'b0);
    resp_phase(1'b0, 1'b0, 32'h0000_0004, 32'd0, 4'd0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
